// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage. Issues loads/stores over a single-outstanding
// REQ/ACK data-memory port, resolves fetch redirects, and registers results into
// the writeback latch. Hung accesses are aborted after TIMEOUT waiting cycles.
module memory_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RESET,

    input  logic        MEM_V,
    input  logic [31:0] MEM_IR,
    input  logic [18:0] MEM_Cst,
    input  logic [63:0] MEM_RES,
    input  logic [63:0] MEM_Address,
    input  logic [63:0] MEM_NPC,
    input  logic        MEM_PC_MUX,
    input  logic [63:0] MEM_Target_Address,

    output logic        MEM_STALL,
    output logic        FE_PC_MUX,
    output logic [63:0] FE_Target_Address,

    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [63:0] DMEM_ADDR,
    output logic [63:0] DMEM_WDATA,
    output logic [7:0]  DMEM_WSTRB,
    input  logic        DMEM_ACK,
    input  logic [63:0] DMEM_RDATA,

    output logic        WB_V,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_DR,
    output logic [63:0] WB_DATA,
    output logic [31:0] WB_IR,
    output logic [18:0] WB_Cst,
    output logic [63:0] WB_NPC,
    output logic        WB_EXC,
    output logic [1:0]  WB_EXC_CAUSE
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    logic [6:0]  opcode;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [2:0]  lane;
    logic        is_load, is_store, mem_op, misaligned, aligned_op;
    logic        done, abort;
    logic [7:0]  size_mask;
    logic [63:0] rdata_sh, load_data;
    logic        writes_rd;

    logic        wb_v_n, wb_rw_n, wb_exc_n;
    logic [1:0]  wb_cause_n;
    logic [63:0] wb_data_n;

    assign opcode      = MEM_IR[6:0];
    assign size        = MEM_IR[13:12];
    assign is_unsigned = MEM_IR[14];
    assign lane        = MEM_Address[2:0];
    assign is_load     = (opcode == OPC_LOAD);
    assign is_store    = (opcode == OPC_STORE);
    assign mem_op      = MEM_V & (is_load | is_store);
    assign aligned_op  = mem_op & ~misaligned;

    assign FE_PC_MUX         = MEM_V & MEM_PC_MUX;
    assign FE_Target_Address = MEM_Target_Address;
    assign DMEM_ADDR         = {MEM_Address[63:3], 3'b000};

    // Alignment check and byte-lane steering for both store and load data
    always_comb begin
        misaligned = 1'b0;
        size_mask  = 8'h00;
        load_data  = '0;
        case (size)
            2'd0: begin misaligned = 1'b0;       size_mask = 8'h01; end
            2'd1: begin misaligned = lane[0];    size_mask = 8'h03; end
            2'd2: begin misaligned = |lane[1:0]; size_mask = 8'h0F; end
            default: begin misaligned = |lane;   size_mask = 8'hFF; end
        endcase
        DMEM_WSTRB = size_mask << lane;
        DMEM_WDATA = MEM_RES << {lane, 3'b000};
        rdata_sh   = DMEM_RDATA >> {lane, 3'b000};
        case (size)
            2'd0:    load_data = {{56{~is_unsigned & rdata_sh[7]}},  rdata_sh[7:0]};
            2'd1:    load_data = {{48{~is_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
            2'd2:    load_data = {{32{~is_unsigned & rdata_sh[31]}}, rdata_sh[31:0]};
            default: load_data = rdata_sh;
        endcase
    end

    // Access FSM state and wait counter; reset drops any outstanding request
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: enter WAIT on an unacknowledged request, leave on ACK or timeout
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (aligned_op && !DMEM_ACK) begin
                    state_next = ST_WAIT;
                    cnt_next   = CW'(1);
                end
            end
            default: begin
                if (DMEM_ACK || cnt == CNT_MAX) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
        endcase
    end

    // Memory port handshake, stall, and completion/abort strobes
    always_comb begin
        DMEM_REQ  = 1'b0;
        MEM_STALL = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                DMEM_REQ  = aligned_op & ~RESET;
                MEM_STALL = aligned_op & ~DMEM_ACK;
                done      = aligned_op & DMEM_ACK;
            end
            default: begin
                DMEM_REQ  = ~RESET;
                MEM_STALL = ~DMEM_ACK & (cnt != CNT_MAX);
                done      = DMEM_ACK;
                abort     = ~DMEM_ACK & (cnt == CNT_MAX);
            end
        endcase
        DMEM_WE = DMEM_REQ & is_store;
    end

    // Writeback values: bubble while stalled, exceptions suppress register write
    always_comb begin
        wb_exc_n   = 1'b0;
        wb_cause_n = 2'd0;
        wb_v_n     = (state == ST_IDLE) ? (MEM_V & ~MEM_STALL) : (done | abort);
        if (state == ST_IDLE && mem_op && misaligned) begin
            wb_exc_n   = 1'b1;
            wb_cause_n = is_load ? 2'd1 : 2'd2;
        end else if (abort) begin
            wb_exc_n   = 1'b1;
            wb_cause_n = 2'd3;
        end
        if (is_load && !wb_exc_n)
            wb_data_n = load_data;
        else if (opcode == OPC_OP_32 || opcode == OPC_OP_IMM32)
            wb_data_n = {{32{MEM_RES[31]}}, MEM_RES[31:0]};
        else
            wb_data_n = MEM_RES;
        writes_rd = opcode inside {OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM32,
                                   OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD};
        wb_rw_n   = wb_v_n & ~wb_exc_n & (MEM_IR[11:7] != 5'd0) & writes_rd;
    end

    // Writeback latch
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WB_V         <= 1'b0;
            WB_RegWrite  <= 1'b0;
            WB_DR        <= '0;
            WB_DATA      <= '0;
            WB_IR        <= '0;
            WB_Cst       <= '0;
            WB_NPC       <= '0;
            WB_EXC       <= 1'b0;
            WB_EXC_CAUSE <= '0;
        end else begin
            WB_V         <= wb_v_n;
            WB_RegWrite  <= wb_rw_n;
            WB_DR        <= MEM_IR[11:7];
            WB_DATA      <= wb_data_n;
            WB_IR        <= MEM_IR;
            WB_Cst       <= MEM_Cst;
            WB_NPC       <= MEM_NPC;
            WB_EXC       <= wb_exc_n;
            WB_EXC_CAUSE <= wb_cause_n;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage with TIMEOUT=4.
module tb_memory_stage;

    localparam int TO = 4;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OP32  = 7'b0111011;
    localparam logic [6:0] OPC_OPI32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    logic        CLK = 1'b0, RESET = 1'b1;
    logic        MEM_V = 1'b0, MEM_PC_MUX = 1'b0, DMEM_ACK = 1'b0;
    logic [31:0] MEM_IR = '0;
    logic [18:0] MEM_Cst = '0;
    logic [63:0] MEM_RES = '0, MEM_Address = '0, MEM_NPC = '0, MEM_Target_Address = '0, DMEM_RDATA = '0;
    logic        MEM_STALL, FE_PC_MUX, DMEM_REQ, DMEM_WE, WB_V, WB_RegWrite, WB_EXC;
    logic [63:0] FE_Target_Address, DMEM_ADDR, DMEM_WDATA, WB_DATA, WB_NPC;
    logic [7:0]  DMEM_WSTRB;
    logic [4:0]  WB_DR;
    logic [31:0] WB_IR;
    logic [18:0] WB_Cst;
    logic [1:0]  WB_EXC_CAUSE;

    memory_stage #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET),
        .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_Cst(MEM_Cst), .MEM_RES(MEM_RES),
        .MEM_Address(MEM_Address), .MEM_NPC(MEM_NPC), .MEM_PC_MUX(MEM_PC_MUX),
        .MEM_Target_Address(MEM_Target_Address),
        .MEM_STALL(MEM_STALL), .FE_PC_MUX(FE_PC_MUX), .FE_Target_Address(FE_Target_Address),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_WSTRB(DMEM_WSTRB), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
        .WB_V(WB_V), .WB_RegWrite(WB_RegWrite), .WB_DR(WB_DR), .WB_DATA(WB_DATA),
        .WB_IR(WB_IR), .WB_Cst(WB_Cst), .WB_NPC(WB_NPC), .WB_EXC(WB_EXC), .WB_EXC_CAUSE(WB_EXC_CAUSE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic v; logic rw; logic [4:0] dr; logic [63:0] data; logic exc; logic [1:0] cause;
        logic [31:0] ir; logic [18:0] cst; logic [63:0] npc;
    } wb_t;
    typedef struct { wb_t w; bit chk_data; } exp_t;

    wb_t  wb_act;
    exp_t sb[$];
    int   checks = 0, errors = 0;

    assign wb_act = {WB_V, WB_RegWrite, WB_DR, WB_DATA, WB_EXC, WB_EXC_CAUSE, WB_IR, WB_Cst, WB_NPC};

    function automatic logic [31:0] mk_ir(logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
        return {7'h2A, 5'd6, 5'd5, f3, rd, opc};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ir, input logic [63:0] res, input logic [63:0] addr);
        MEM_V = v; MEM_IR = ir; MEM_RES = res; MEM_Address = addr;
        MEM_Cst = 19'($urandom); MEM_NPC = {$urandom, $urandom};
        MEM_PC_MUX = 1'b0; MEM_Target_Address = {$urandom, $urandom};
    endtask

    function automatic void push(logic rw, logic [63:0] data, logic exc, logic [1:0] cause, bit chk);
        exp_t e;
        e.w = {1'b1, rw, MEM_IR[11:7], data, exc, cause, MEM_IR, MEM_Cst, MEM_NPC};
        e.chk_data = chk;
        sb.push_back(e);
    endfunction

    task automatic test_reset;
        @(negedge CLK);
        RESET = 1'b1; drive(1'b1, mk_ir(3'd3, 5'd4, OPC_LOAD), 64'h0, 64'h1000); DMEM_ACK = 1'b0;
        #1; checks++;
        if (DMEM_REQ !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", DMEM_REQ); end
        @(posedge CLK); #1; checks++;
        if (wb_act !== '0) begin errors++; $display("FAIL rst_wb got=%h exp=0", wb_act); end
        @(negedge CLK);
        RESET = 1'b0; drive(1'b0, mk_ir(3'd0, 5'd3, OPC_OP), 64'h7, 64'h0); DMEM_ACK = 1'b1;
        #1; checks++;
        if (DMEM_REQ !== 1'b0 || FE_PC_MUX !== 1'b0) begin
            errors++; $display("FAIL idle_req got=%b%b exp=00", DMEM_REQ, FE_PC_MUX);
        end
        @(posedge CLK); #1; checks++;
        if (WB_V !== 1'b0) begin errors++; $display("FAIL idle_wbv got=%b exp=0", WB_V); end
        DMEM_ACK = 1'b0;
    endtask

    task automatic test_alu;
        typedef struct packed { logic [31:0] ir; logic [63:0] res; logic rw; logic [63:0] data; } vec_t;
        vec_t tv[6];
        exp_t e; wb_t got;
        tv[0] = '{mk_ir(3'd0, 5'd3,  OPC_OP),    64'h5,                   1'b1, 64'h5};
        tv[1] = '{mk_ir(3'd0, 5'd0,  OPC_OP),    64'h5,                   1'b0, 64'h5};
        tv[2] = '{mk_ir(3'd0, 5'd5,  OPC_OP32),  64'h0000_0001_8000_0000, 1'b1, 64'hFFFF_FFFF_8000_0000};
        tv[3] = '{mk_ir(3'd0, 5'd6,  OPC_OPI32), 64'hFFFF_FFFF_7FFF_FFFF, 1'b1, 64'h0000_0000_7FFF_FFFF};
        tv[4] = '{mk_ir(3'd0, 5'd10, OPC_LUI),   64'h1234_5000,           1'b1, 64'h1234_5000};
        tv[5] = '{mk_ir(3'd0, 5'd1,  OPC_JAL),   64'h104,                 1'b1, 64'h104};
        DMEM_ACK = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            drive(1'b1, tv[i].ir, tv[i].res, 64'h1001);
            push(tv[i].rw, tv[i].data, 1'b0, 2'd0, 1'b1);
            #1; checks++;
            if (MEM_STALL !== 1'b0 || DMEM_REQ !== 1'b0) begin
                errors++; $display("FAIL alu_stall[%0d] got=%b%b exp=00", i, MEM_STALL, DMEM_REQ);
            end
            @(posedge CLK); #1; checks++;
            if (WB_V !== 1'b1 || sb.size() == 0) begin
                errors++; $display("FAIL alu_wbv[%0d] got=%b exp=1", i, WB_V);
            end else begin
                e = sb.pop_front(); got = wb_act;
                if (got !== e.w) begin errors++; $display("FAIL alu_wb[%0d] got=%h exp=%h", i, got, e.w); end
            end
        end
    endtask

    task automatic test_load_ext;
        typedef struct packed { logic [2:0] f3; logic [63:0] addr; logic [63:0] rdata; logic [63:0] data; } vec_t;
        vec_t tv[6];
        exp_t e; wb_t got;
        tv[0] = '{3'd0, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        tv[1] = '{3'd4, 64'h1003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080};
        tv[2] = '{3'd2, 64'h1004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321};
        tv[3] = '{3'd6, 64'h1004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321};
        tv[4] = '{3'd1, 64'h1002, 64'h0000_0000_9ABC_0000, 64'hFFFF_FFFF_FFFF_9ABC};
        tv[5] = '{3'd5, 64'h1002, 64'h0000_0000_9ABC_0000, 64'h0000_0000_0000_9ABC};
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            drive(1'b1, mk_ir(tv[i].f3, 5'd7, OPC_LOAD), 64'hDEAD, tv[i].addr);
            DMEM_ACK = 1'b1; DMEM_RDATA = tv[i].rdata;
            push(1'b1, tv[i].data, 1'b0, 2'd0, 1'b1);
            #1; checks++;
            if ({MEM_STALL, DMEM_REQ, DMEM_WE} !== 3'b010 || DMEM_ADDR !== 64'h1000) begin
                errors++; $display("FAIL ld_port[%0d] got=%b%b%b/%h exp=010/1000", i, MEM_STALL, DMEM_REQ, DMEM_WE, DMEM_ADDR);
            end
            @(posedge CLK); #1; checks++;
            if (WB_V !== 1'b1 || sb.size() == 0) begin
                errors++; $display("FAIL ld_wbv[%0d] got=%b exp=1", i, WB_V);
            end else begin
                e = sb.pop_front(); got = wb_act;
                if (got !== e.w) begin errors++; $display("FAIL ld_wb[%0d] got=%h exp=%h", i, got, e.w); end
            end
        end
        DMEM_ACK = 1'b0;
    endtask

    task automatic test_store;
        typedef struct packed { logic [2:0] f3; logic [63:0] addr; logic [63:0] res; logic [7:0] strb; logic [63:0] wdata; logic [63:0] daddr; } vec_t;
        vec_t tv[4];
        exp_t e; wb_t got;
        tv[0] = '{3'd1, 64'h1006, 64'hABCD,      8'hC0, 64'hABCD_0000_0000_0000, 64'h1000};
        tv[1] = '{3'd0, 64'h1001, 64'h12,        8'h02, 64'h0000_0000_0000_1200, 64'h1000};
        tv[2] = '{3'd2, 64'h1004, 64'hDEADBEEF,  8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h1000};
        tv[3] = '{3'd3, 64'h1008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h1008};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            drive(1'b1, mk_ir(tv[i].f3, 5'd5, OPC_STORE), tv[i].res, tv[i].addr);
            DMEM_ACK = 1'b1;
            push(1'b0, tv[i].res, 1'b0, 2'd0, 1'b1);
            #1; checks++;
            if ({MEM_STALL, DMEM_REQ, DMEM_WE} !== 3'b011 || DMEM_WSTRB !== tv[i].strb ||
                DMEM_WDATA !== tv[i].wdata || DMEM_ADDR !== tv[i].daddr) begin
                errors++; $display("FAIL st_port[%0d] got=%b%b%b/%h/%h/%h exp=011/%h/%h/%h", i, MEM_STALL, DMEM_REQ, DMEM_WE,
                                   DMEM_WSTRB, DMEM_WDATA, DMEM_ADDR, tv[i].strb, tv[i].wdata, tv[i].daddr);
            end
            @(posedge CLK); #1; checks++;
            if (WB_V !== 1'b1 || sb.size() == 0) begin
                errors++; $display("FAIL st_wbv[%0d] got=%b exp=1", i, WB_V);
            end else begin
                e = sb.pop_front(); got = wb_act;
                if (got !== e.w) begin errors++; $display("FAIL st_wb[%0d] got=%h exp=%h", i, got, e.w); end
            end
        end
        DMEM_ACK = 1'b0;
    endtask

    task automatic test_wait_load;
        int stall_cycles = 0;
        exp_t e; wb_t got;
        @(negedge CLK);
        drive(1'b1, mk_ir(3'd3, 5'd9, OPC_LOAD), 64'h0, 64'h2008);
        DMEM_ACK = 1'b0; DMEM_RDATA = '0;
        push(1'b1, 64'h1122_3344_5566_7788, 1'b0, 2'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge CLK);
            if (c == 2) begin DMEM_ACK = 1'b1; DMEM_RDATA = 64'h1122_3344_5566_7788; end
            #1;
            if (MEM_STALL === 1'b1) stall_cycles++;
            checks++;
            if (DMEM_REQ !== 1'b1 || DMEM_ADDR !== 64'h2008) begin
                errors++; $display("FAIL wait_req[%0d] got=%b/%h exp=1/2008", c, DMEM_REQ, DMEM_ADDR);
            end
            @(posedge CLK); #1; checks++;
            if (c < 2) begin
                if (WB_V !== 1'b0) begin errors++; $display("FAIL wait_bubble[%0d] got=%b exp=0", c, WB_V); end
            end else if (WB_V !== 1'b1 || sb.size() == 0) begin
                errors++; $display("FAIL wait_wbv got=%b exp=1", WB_V);
            end else begin
                e = sb.pop_front(); got = wb_act;
                if (got !== e.w) begin errors++; $display("FAIL wait_wb got=%h exp=%h", got, e.w); end
            end
        end
        checks++;
        if (stall_cycles != 2) begin errors++; $display("FAIL wait_stall_cycles got=%0d exp=2", stall_cycles); end
        DMEM_ACK = 1'b0;
    endtask

    task automatic test_misaligned;
        typedef struct packed { logic [2:0] f3; logic [6:0] opc; logic [63:0] addr; logic [1:0] cause; } vec_t;
        vec_t tv[3];
        exp_t e; wb_t got;
        tv[0] = '{3'd2, OPC_LOAD,  64'h1002, 2'd1};
        tv[1] = '{3'd3, OPC_STORE, 64'h1004, 2'd2};
        tv[2] = '{3'd1, OPC_LOAD,  64'h1001, 2'd1};
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            drive(1'b1, mk_ir(tv[i].f3, 5'd4, tv[i].opc), 64'h55, tv[i].addr);
            DMEM_ACK = 1'b0;
            push(1'b0, 64'h0, 1'b1, tv[i].cause, 1'b0);
            #1; checks++;
            if (DMEM_REQ !== 1'b0 || MEM_STALL !== 1'b0) begin
                errors++; $display("FAIL mis_req[%0d] got=%b%b exp=00", i, DMEM_REQ, MEM_STALL);
            end
            @(posedge CLK); #1; checks++;
            if (WB_V !== 1'b1 || sb.size() == 0) begin
                errors++; $display("FAIL mis_wbv[%0d] got=%b exp=1", i, WB_V);
            end else begin
                e = sb.pop_front(); got = wb_act; got.data = e.w.data;
                if (got !== e.w) begin errors++; $display("FAIL mis_wb[%0d] got=%h exp=%h", i, got, e.w); end
            end
        end
    endtask

    task automatic test_timeout;
        int  req_cycles = 0;
        bit  aborted = 0;
        exp_t e; wb_t got;
        @(negedge CLK);
        drive(1'b1, mk_ir(3'd3, 5'd8, OPC_LOAD), 64'h0, 64'h3000);
        DMEM_ACK = 1'b0;
        push(1'b0, 64'h0, 1'b1, 2'd3, 1'b0);
        for (int c = 0; c < TO + 4 && !aborted; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            if (DMEM_REQ === 1'b1) req_cycles++;
            if (c == TO) begin
                checks++;
                if (MEM_STALL !== 1'b0) begin errors++; $display("FAIL to_stall_release got=%b exp=0", MEM_STALL); end
            end
            @(posedge CLK); #1;
            if (WB_V === 1'b1) begin
                aborted = 1; checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL to_sb got=WB_V exp=entry");
                end else begin
                    e = sb.pop_front(); got = wb_act; got.data = e.w.data;
                    if (got !== e.w) begin errors++; $display("FAIL to_wb got=%h exp=%h", got, e.w); end
                end
            end
        end
        checks++;
        if (!aborted) begin errors++; $display("FAIL to_abort got=none exp=WB_V"); void'(sb.pop_front()); end
        checks++;
        if (req_cycles != TO + 1) begin errors++; $display("FAIL to_req_cycles got=%0d exp=%0d", req_cycles, TO + 1); end
        @(negedge CLK);
        drive(1'b0, mk_ir(3'd3, 5'd8, OPC_LOAD), 64'h0, 64'h3000); DMEM_ACK = 1'b1;
        #1; checks++;
        if (DMEM_REQ !== 1'b0) begin errors++; $display("FAIL to_req_after got=%b exp=0", DMEM_REQ); end
        @(posedge CLK); #1; checks++;
        if (WB_V !== 1'b0) begin errors++; $display("FAIL to_late_ack got=%b exp=0", WB_V); end
        DMEM_ACK = 1'b0;
    endtask

    task automatic test_reset_wait;
        @(negedge CLK);
        drive(1'b1, mk_ir(3'd3, 5'd2, OPC_LOAD), 64'h0, 64'h4000); DMEM_ACK = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1; #1; checks++;
        if (DMEM_REQ !== 1'b0) begin errors++; $display("FAIL rw_req got=%b exp=0", DMEM_REQ); end
        @(posedge CLK); #1; checks++;
        if (wb_act !== '0) begin errors++; $display("FAIL rw_wb got=%h exp=0", wb_act); end
        @(negedge CLK);
        RESET = 1'b0; drive(1'b0, mk_ir(3'd3, 5'd2, OPC_LOAD), 64'h0, 64'h4000); DMEM_ACK = 1'b1;
        #1; checks++;
        if (DMEM_REQ !== 1'b0) begin errors++; $display("FAIL rw_req_after got=%b exp=0", DMEM_REQ); end
        @(posedge CLK); #1; checks++;
        if (WB_V !== 1'b0) begin errors++; $display("FAIL rw_late_ack got=%b exp=0", WB_V); end
        DMEM_ACK = 1'b0;
    endtask

    task automatic test_branch;
        exp_t e; wb_t got;
        @(negedge CLK);
        drive(1'b1, mk_ir(3'd0, 5'd8, OPC_BR), 64'h99, 64'h0);
        MEM_PC_MUX = 1'b1; MEM_Target_Address = 64'h2000; DMEM_ACK = 1'b0;
        push(1'b0, 64'h99, 1'b0, 2'd0, 1'b1);
        #1; checks++;
        if (FE_PC_MUX !== 1'b1 || FE_Target_Address !== 64'h2000 || DMEM_REQ !== 1'b0) begin
            errors++; $display("FAIL br_fe got=%b/%h/%b exp=1/2000/0", FE_PC_MUX, FE_Target_Address, DMEM_REQ);
        end
        @(posedge CLK); #1; checks++;
        if (WB_V !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL br_wbv got=%b exp=1", WB_V);
        end else begin
            e = sb.pop_front(); got = wb_act;
            if (got !== e.w) begin errors++; $display("FAIL br_wb got=%h exp=%h", got, e.w); end
        end
        @(negedge CLK);
        drive(1'b0, mk_ir(3'd0, 5'd8, OPC_BR), 64'h99, 64'h0); MEM_PC_MUX = 1'b1;
        #1; checks++;
        if (FE_PC_MUX !== 1'b0) begin errors++; $display("FAIL br_invalid got=%b exp=0", FE_PC_MUX); end
        MEM_PC_MUX = 1'b0;
    endtask

    task automatic test_back_to_back;
        exp_t e; wb_t got;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            case (i)
                0: begin drive(1'b1, mk_ir(3'd0, 5'd12, OPC_OP), 64'hA1, 64'h0); DMEM_ACK = 1'b0;
                         push(1'b1, 64'hA1, 1'b0, 2'd0, 1'b1); end
                1: begin drive(1'b1, mk_ir(3'd4, 5'd13, OPC_LOAD), 64'h0, 64'h5005);
                         DMEM_ACK = 1'b1; DMEM_RDATA = 64'h0000_F000_0000_0000;
                         push(1'b1, 64'hF0, 1'b0, 2'd0, 1'b1); end
                2: begin drive(1'b1, mk_ir(3'd3, 5'd0, OPC_STORE), 64'h77, 64'h5008); DMEM_ACK = 1'b1;
                         push(1'b0, 64'h77, 1'b0, 2'd0, 1'b1); end
                default: begin drive(1'b1, mk_ir(3'd0, 5'd14, OPC_OP32), 64'h1_0000_0002, 64'h0); DMEM_ACK = 1'b0;
                         push(1'b1, 64'h2, 1'b0, 2'd0, 1'b1); end
            endcase
            @(posedge CLK); #1; checks++;
            if (WB_V !== 1'b1 || sb.size() == 0) begin
                errors++; $display("FAIL b2b_wbv[%0d] got=%b exp=1", i, WB_V);
            end else begin
                e = sb.pop_front(); got = wb_act;
                if (got !== e.w) begin errors++; $display("FAIL b2b_wb[%0d] got=%h exp=%h", i, got, e.w); end
            end
        end
        DMEM_ACK = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_store();
        test_wait_load();
        test_misaligned();
        test_timeout();
        test_reset_wait();
        test_branch();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
